dmem_access_arbiter: RTL and testbench
======================================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single-port synchronous data memory between two requesters:
//  port A (pipeline MEM stage) and port B (debug/program-loader).
//  Grants one access per cycle and drives the memory command. Tracks the
//  1-cycle read latency and returns formatted load data (LB/LH/LW/LBU/LHU)
//  to the port that issued the read.
//  Rejects misaligned and illegal-funct3 accesses. Sits between the MEM
//  stage / debug bus and the data memory.
// PARAMETERS
//  DATA_WIDTH  32  data/address width (from defines)
//  MAX_WAIT    4   consecutive denied cycles after which port B overrides A
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  a_req_i       in   1   port A access request
//  a_we_i        in   1   port A: 1=store, 0=load
//  a_funct3_i    in   3   port A RISC-V load/store funct3
//  a_addr_i      in   32  port A byte address
//  a_wdata_i     in   32  port A store data (low bytes used for SB/SH)
//  a_gnt_o       out  1   port A request accepted this cycle (comb.)
//  a_rvalid_o    out  1   port A load data valid (cycle after grant)
//  a_rdata_o     out  32  port A extended load data
//  a_err_o       out  1   port A misaligned/illegal pulse (cycle after grant)
//  b_*           --   --  port B: identical set to a_* (req,we,funct3,addr,wdata,gnt,rvalid,rdata,err)
//  mem_we_o      out  1   data memory MemWrite_en
//  mem_re_o      out  1   data memory MemRead_en
//  mem_funct3_o  out  3   data memory funct3
//  mem_addr_o    out  32  data memory byte address
//  mem_wdata_o   out  32  data memory write data
//  mem_rdata_i   in   32  data memory registered read word
// BEHAVIOUR
//  Reset: all outputs 0; wait_cnt=0; pend_vld=0. Pending read is dropped;
//   no rvalid/err after reset release.
//  Arbitration (comb., same cycle):
//   - A wins if a_req_i, unless b_req_i && wait_cnt==MAX_WAIT -> B wins.
//   - Otherwise B wins when b_req_i && !a_req_i.
//   - Exactly one gnt_o high at most.
//  wait_cnt: +1 each cycle B requests and is denied (saturate at MAX_WAIT);
//   cleared when B is granted or b_req_i=0.
//  Command: granted port's fields drive mem_* the same cycle.
//   mem_we_o = gnt & we & legal; mem_re_o = gnt & !we & legal.
//   Idle cycle: mem_we_o=mem_re_o=0.
//  Legality:
//   - Stores: funct3 in {SB=000, SH=001, SW=010}.
//   - Loads: {LB=000, LH=001, LW=010, LBU=100, LHU=101}.
//   - Alignment: H needs addr[0]=0; W needs addr[1:0]=00.
//   - Illegal access is still granted, memory is not touched, and err_o
//     pulses 1 cycle later.
//  Pending register (set at edge after grant): pend_vld, port id, funct3,
//   addr[1:0], is_load, illegal.
//  Response in cycle N+1 for grant in cycle N:
//   - Legal load -> <port>_rvalid_o=1, rdata = mem_rdata_i lane-selected by
//     addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
//   - LW: rdata = mem_rdata_i unchanged.
//   - Store: no rvalid.
//   - Illegal access: <port>_err_o=1, rvalid=0, rdata=0.
//   - rdata_o=0 whenever rvalid_o=0.
//  Throughput: one grant per cycle; back-to-back reads from either or
//   alternating ports each return in order, 1 cycle after their grant.
//  Simultaneous read-response and new grant in the same cycle is allowed
//   (pipelined). Port of a response never changes after issue.
// TESTING
//  1 Reset: hold rst_n=0 mid-read -> no a_rvalid_o after release; all outputs 0.
//  2 A SW 0xDEADBEEF @0x10, then A LB @0x13 -> rvalid next cycle, rdata=0xFFFFFFDE;
//    LBU @0x13 -> 0x000000DE.
//  3 A SH 0x8001 @0x12, LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001;
//    LW @0x10 -> 0x8001BEEF.
//  4 A and B req every cycle, MAX_WAIT=4 -> B granted on 5th cycle, then
//    4 A grants, repeat; never both gnt.
//  5 LW @0x02, SH @0x01, funct3=011 -> gnt=1, mem_we/re=0, err_o=1 next
//    cycle, memory unchanged.
//  6 Alternating A/B LW every cycle @0x0/0x4 -> each rvalid on its own port,
//    1 cycle after its grant, correct word.

Source files
------------

// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data memory.
// Issues one access per cycle and returns formatted load data a cycle later.
module dmem_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [2:0]            a_funct3_i,
    input  logic [DATA_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    output logic                  a_err_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [2:0]            b_funct3_i,
    input  logic [DATA_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  b_err_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    output logic [2:0]            mem_funct3_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [WW-1:0]         wait_cnt;
    logic                  b_win;
    logic                  any_gnt;
    logic                  sel_we;
    logic [2:0]            sel_f3;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  f3_ok;
    logic                  align_ok;
    logic                  legal;

    logic                  pend_vld;
    logic                  pend_port;
    logic [2:0]            pend_f3;
    logic [1:0]            pend_off;
    logic                  pend_load;
    logic                  pend_ill;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] fmt;
    logic                  resp_rd;
    logic                  resp_err;

    // B takes over once it has been starved for MAX_WAIT cycles in a row.
    assign b_win   = b_req_i && (!a_req_i || wait_cnt == WMAX);
    assign b_gnt_o = rst_n && b_win;
    assign a_gnt_o = rst_n && a_req_i && !b_win;
    assign any_gnt = a_gnt_o || b_gnt_o;

    assign sel_we    = b_gnt_o ? b_we_i     : a_we_i;
    assign sel_f3    = b_gnt_o ? b_funct3_i : a_funct3_i;
    assign sel_addr  = b_gnt_o ? b_addr_i   : a_addr_i;
    assign sel_wdata = b_gnt_o ? b_wdata_i  : a_wdata_i;

    always_comb begin
        f3_ok = 1'b0;
        unique case (1'b1)
            sel_f3 == 3'b000: f3_ok = 1'b1;
            sel_f3 == 3'b001: f3_ok = 1'b1;
            sel_f3 == 3'b010: f3_ok = 1'b1;
            sel_f3 == 3'b100: f3_ok = !sel_we;
            sel_f3 == 3'b101: f3_ok = !sel_we;
            default:          f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        align_ok = 1'b1;
        if (sel_f3[1:0] == 2'b01) align_ok = !sel_addr[0];
        if (sel_f3[1:0] == 2'b10) align_ok = sel_addr[1:0] == 2'b00;
    end

    assign legal = f3_ok && align_ok;

    assign mem_we_o     = any_gnt && sel_we && legal;
    assign mem_re_o     = any_gnt && !sel_we && legal;
    assign mem_funct3_o = any_gnt ? sel_f3    : 3'b000;
    assign mem_addr_o   = any_gnt ? sel_addr  : '0;
    assign mem_wdata_o  = any_gnt ? sel_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!b_req_i || b_gnt_o) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WMAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_port <= 1'b0;
            pend_f3   <= 3'b000;
            pend_off  <= 2'b00;
            pend_load <= 1'b0;
            pend_ill  <= 1'b0;
        end else begin
            pend_vld  <= any_gnt;
            pend_port <= b_gnt_o;
            pend_f3   <= sel_f3;
            pend_off  <= sel_addr[1:0];
            pend_load <= !sel_we;
            pend_ill  <= !legal;
        end
    end

    assign lane = mem_rdata_i >> {pend_off, 3'b000};

    always_comb begin
        fmt = '0;
        unique case (pend_f3)
            3'b000:  fmt = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  fmt = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            3'b010:  fmt = mem_rdata_i;
            3'b100:  fmt = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  fmt = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: fmt = '0;
        endcase
    end

    assign resp_rd  = pend_vld && pend_load && !pend_ill;
    assign resp_err = pend_vld && pend_ill;

    assign a_rvalid_o = resp_rd && !pend_port;
    assign b_rvalid_o = resp_rd && pend_port;
    assign a_err_o    = resp_err && !pend_port;
    assign b_err_o    = resp_err && pend_port;
    assign a_rdata_o  = a_rvalid_o ? fmt : '0;
    assign b_rdata_o  = b_rvalid_o ? fmt : '0;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter with a byte-level memory model.
// Includes the synchronous SRAM the arbiter drives.
module tb_dmem_access_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        req;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        logic        is_rd;
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_req_i = 0, a_we_i = 0, b_req_i = 0, b_we_i = 0;
    logic [2:0]  a_funct3_i = 0, b_funct3_i = 0;
    logic [31:0] a_addr_i = 0, a_wdata_i = 0, b_addr_i = 0, b_wdata_i = 0;
    logic        a_gnt_o, a_rvalid_o, a_err_o;
    logic        b_gnt_o, b_rvalid_o, b_err_o;
    logic [31:0] a_rdata_o, b_rdata_o;
    logic        mem_we_o, mem_re_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int denied = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [7:0]  refm [0:255];
    logic [31:0] sram [0:63];

    dmem_access_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_funct3_i(a_funct3_i),
        .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
        .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_funct3_i(b_funct3_i),
        .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
        .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
        .mem_funct3_o(mem_funct3_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port data memory.
    always @(posedge clk) begin
        if (mem_we_o) begin
            case (mem_funct3_o[1:0])
                2'b00: sram[mem_addr_o[7:2]][8*mem_addr_o[1:0] +: 8] <= mem_wdata_o[7:0];
                2'b01: sram[mem_addr_o[7:2]][8*mem_addr_o[1:0] +: 16] <= mem_wdata_o[15:0];
                default: sram[mem_addr_o[7:2]] <= mem_wdata_o;
            endcase
        end
        if (mem_re_o) mem_rdata_i <= sram[mem_addr_o[7:2]];
    end

    function automatic req_t mk(input logic r, input logic w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d);
        req_t x;
        x.req = r; x.we = w; x.f3 = f; x.addr = a; x.wdata = d;
        return x;
    endfunction

    function automatic bit legal_m(input req_t x);
        int sz;
        bit ok;
        sz = 1 << x.f3[1:0];
        if (x.we) ok = (x.f3 <= 3'd2);
        else ok = (x.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return ok && (x.addr % sz == 0);
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] f, input logic [7:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = refm[a]; b1 = refm[8'(a + 1)];
        b2 = refm[8'(a + 2)]; b3 = refm[8'(a + 3)];
        case (f)
            3'd0: return {{24{b0[7]}}, b0};
            3'd1: return {{16{b1[7]}}, b1, b0};
            3'd2: return {b3, b2, b1, b0};
            3'd4: return {24'd0, b0};
            default: return {16'd0, b1, b0};
        endcase
    endfunction

    task automatic drive(input req_t a, input req_t b);
        bit aw, bw, lg;
        req_t g;
        exp_t e;
        @(negedge clk);
        a_req_i = a.req; a_we_i = a.we; a_funct3_i = a.f3;
        a_addr_i = a.addr; a_wdata_i = a.wdata;
        b_req_i = b.req; b_we_i = b.we; b_funct3_i = b.f3;
        b_addr_i = b.addr; b_wdata_i = b.wdata;
        #1;
        bw = b.req && (!a.req || denied >= MAX_WAIT);
        aw = a.req && !bw;
        if (b.req && !bw) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
        else denied = 0;
        tests++;
        if ({a_gnt_o, b_gnt_o} !== {aw, bw}) begin
            fails++;
            $display("FAIL gnt cyc=%0d got a=%b b=%b want a=%b b=%b",
                     cyc, a_gnt_o, b_gnt_o, aw, bw);
        end
        if (!(aw || bw)) begin
            tests++;
            if ({mem_we_o, mem_re_o} !== 2'b00) begin
                fails++;
                $display("FAIL idle_cmd cyc=%0d got we=%b re=%b want 0 0",
                         cyc, mem_we_o, mem_re_o);
            end
            return;
        end
        g = bw ? b : a;
        lg = legal_m(g);
        tests++;
        if ({mem_we_o, mem_re_o} !== {g.we && lg, !g.we && lg}) begin
            fails++;
            $display("FAIL cmd cyc=%0d got we=%b re=%b want we=%b re=%b",
                     cyc, mem_we_o, mem_re_o, g.we && lg, !g.we && lg);
        end
        if (lg) begin
            tests++;
            if (mem_addr_o !== g.addr || mem_funct3_o !== g.f3 ||
                (g.we && mem_wdata_o !== g.wdata)) begin
                fails++;
                $display("FAIL fields cyc=%0d got a=%h f=%0d d=%h want a=%h f=%0d d=%h",
                         cyc, mem_addr_o, mem_funct3_o, mem_wdata_o,
                         g.addr, g.f3, g.wdata);
            end
        end
        e.due = cyc + 1; e.is_rd = 0; e.is_err = 0; e.data = 0;
        if (!lg) e.is_err = 1;
        else if (!g.we) begin
            e.is_rd = 1;
            e.data = load_m(g.f3, g.addr[7:0]);
        end else begin
            for (int i = 0; i < (1 << g.f3[1:0]); i++)
                refm[8'(g.addr[7:0] + i)] = g.wdata[8*i +: 8];
        end
        if (e.is_rd || e.is_err) begin
            if (bw) qb.push_back(e);
            else qa.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    endtask

    task automatic mon(input bit p);
        exp_t e;
        logic rv, er;
        logic [31:0] rd;
        e.due = 0; e.is_rd = 0; e.is_err = 0; e.data = 0;
        rv = p ? b_rvalid_o : a_rvalid_o;
        er = p ? b_err_o : a_err_o;
        rd = p ? b_rdata_o : a_rdata_o;
        if (!p && qa.size() > 0 && qa[0].due <= cyc) e = qa.pop_front();
        if (p && qb.size() > 0 && qb[0].due <= cyc) e = qb.pop_front();
        tests++;
        if ({rv, er, rd} !== {e.is_rd, e.is_err, e.data}) begin
            fails++;
            $display("FAIL resp_%s cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     p ? "b" : "a", cyc, rv, er, rd, e.is_rd, e.is_err, e.data);
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    task automatic chk_all_zero(input string nm);
        tests++;
        if ({a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o, b_gnt_o, b_rvalid_o,
             b_rdata_o, b_err_o, mem_we_o, mem_re_o, mem_funct3_o,
             mem_addr_o, mem_wdata_o} !== '0) begin
            fails++;
            $display("FAIL %s outputs not all zero (ag=%b av=%b bg=%b bv=%b we=%b re=%b)",
                     nm, a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o, mem_we_o, mem_re_o);
        end
    endtask

    initial begin
        req_t ra, rb;
        for (int i = 0; i < 256; i++) refm[i] = 8'h00;
        for (int i = 0; i < 64; i++) sram[i] = 32'h0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        idle(2);

        // Reset arriving while a read is outstanding drops it.
        drive(mk(1, 0, 3'd2, 32'h20, 0), mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b0;
        qa.delete(); qb.delete(); denied = 0;
        a_req_i = 0; b_req_i = 0;
        #1 chk_all_zero("reset_midread");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        drive(mk(1, 1, 3'd2, 32'h10, 32'hDEADBEEF), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd0, 32'h13, 0), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd4, 32'h13, 0), mk(0, 0, 0, 0, 0));
        drive(mk(1, 1, 3'd1, 32'h12, 32'h0000_8001), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd1, 32'h12, 0), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd5, 32'h12, 0), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd2, 32'h10, 0), mk(0, 0, 0, 0, 0));
        idle(1);

        for (int i = 0; i < 20; i++)
            drive(mk(1, 0, 3'd2, 32'h10, 0), mk(1, 0, 3'd4, 32'h11, 0));
        idle(1);

        drive(mk(1, 0, 3'd2, 32'h02, 0), mk(0, 0, 0, 0, 0));
        drive(mk(1, 1, 3'd1, 32'h01, 32'h1234), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd3, 32'h00, 0), mk(0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0), mk(1, 1, 3'd6, 32'h10, 32'hFFFF));
        drive(mk(1, 0, 3'd2, 32'h00, 0), mk(0, 0, 0, 0, 0));
        drive(mk(1, 0, 3'd2, 32'h10, 0), mk(0, 0, 0, 0, 0));

        drive(mk(1, 1, 3'd2, 32'h0, 32'h11223344), mk(0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0), mk(1, 1, 3'd2, 32'h4, 32'hA5A5_5A5A));
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(mk(1, 0, 3'd2, 32'h0, 0), mk(0, 0, 0, 0, 0));
            else drive(mk(0, 0, 0, 0, 0), mk(1, 0, 3'd2, 32'h4, 0));
        end

        for (int i = 0; i < 2000; i++) begin
            ra = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1),
                    3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);
            rb = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1),
                    3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);
            if ($urandom_range(0, 1) == 1) ra.addr[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) rb.addr[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0 && ra.f3[2] && ra.we) ra.f3[2] = 1'b0;
            drive(ra, rb);
        end
        idle(3);

        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain got qa=%0d qb=%0d want 0 0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
